// File: rtl/mem_handshake_ctrl.sv
// Memory-side bus stage: accepts an MFA request, waits WAIT_STATES cycles, then
// completes it against a byte store and answers with a 4-phase MFC handshake.
module mem_handshake_ctrl #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MFA,
  input  logic              READ_WRITE,
  input  logic              WORD_BYTE,
  input  logic [ADDR_W-1:0] MEMADD,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MFC,
  output logic              Fault,
  output logic              Busy,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [7:0]        LoadData,
  output logic [1:0]        DbgState
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q, wb_q;
  logic [31:0]       wdata_q;
  logic [31:0]       dout_q, dout_d;
  logic              mfc_q, mfc_d;
  logic              fault_q, fault_d;
  logic              latch_en, acc_we, load_we;
  logic [31:0]       rd_word;

  // Store is deliberately outside the reset domain so contents survive Reset.
  logic [7:0] mem_q [2**ADDR_W];

  assign rd_word = {mem_q[addr_q + ADDR_W'(3)], mem_q[addr_q + ADDR_W'(2)],
                    mem_q[addr_q + ADDR_W'(1)], mem_q[addr_q]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    mfc_d    = mfc_q;
    fault_d  = fault_q;
    latch_en = 1'b0;
    acc_we   = 1'b0;
    load_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (MFA) begin
          latch_en = 1'b1;
          cnt_d    = WS;
          state_d  = S_WAIT;
        end else begin
          load_we = LoadEn & Reset;
        end
      end
      S_WAIT: begin
        if (!MFA) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          mfc_d   = 1'b1;
          if (wb_q && (addr_q[1:0] != 2'b00)) begin
            fault_d = 1'b1;
            dout_d  = 32'h0;
          end else if (rw_q) begin
            dout_d = wb_q ? rd_word : {24'h0, mem_q[addr_q]};
          end else begin
            acc_we = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (!MFA) begin
          state_d = S_IDLE;
          mfc_d   = 1'b0;
          fault_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wb_q    <= 1'b0;
      wdata_q <= 32'h0;
      dout_q  <= 32'h0;
      mfc_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      fault_q <= fault_d;
      if (latch_en) begin
        addr_q  <= MEMADD;
        rw_q    <= READ_WRITE;
        wb_q    <= WORD_BYTE;
        wdata_q <= DataIn;
      end
    end
  end

  // Preload and bus writes are mutually exclusive: one needs IDLE, the other WAIT.
  always_ff @(posedge Clk) begin
    if (load_we) mem_q[LoadAddr] <= LoadData;
    if (acc_we) begin
      if (wb_q) begin
        for (int i = 0; i < 4; i++) mem_q[addr_q + ADDR_W'(i)] <= wdata_q[8*i +: 8];
      end else begin
        mem_q[addr_q] <= wdata_q[7:0];
      end
    end
  end

  assign DataOut  = dout_q;
  assign MFC      = mfc_q;
  assign Fault    = fault_q;
  assign Busy     = (state_q != S_IDLE);
  assign DbgState = state_q;

endmodule
